conv3x3_mac: RTL and testbench



---
 rtl/conv_pkg.sv | 15 +
 rtl/conv_if.sv | 26 ++
 rtl/mac3x3_tree.sv | 41 ++++
 rtl/conv3x3_mac.sv | 91 +++++++++
 tb/tb_conv3x3_mac.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared types, widths and output conditioning for the 3x3 convolution MAC
package conv_pkg;
  localparam int MAC_LATENCY = 6;
  typedef logic signed [7:0] window_t [9];
  function automatic int acc_width(input int dw, input int ww, input int c);
    return dw + ww + 4 + $clog2(c);
  endfunction
  function automatic logic signed [63:0] relu_sat(input logic signed [63:0] v, input int ow, input bit relu);
    logic signed [63:0] hi, lo, r;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    r = (relu && v < 64'sd0) ? 64'sd0 : v;
    return r > hi ? hi : r < lo ? lo : r;
  endfunction
endpackage

// File: rtl/conv_if.sv
// conv_if: window stream, weight-write port and result stream of the 3x3 convolution MAC
interface conv_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int W_WIDTH     = 8,
  parameter int CHANNEL_NUM = 3,
  parameter int OUT_WIDTH   = 8
);
  localparam int AW = $clog2(CHANNEL_NUM * 9 + 1);
  logic                          data_valid_i;
  logic signed [DATA_WIDTH-1:0]  data_i [9];
  logic                          sop_i, eop_i, sof_i, eof_i;
  logic                          w_we_i;
  logic [AW-1:0]                 w_addr_i;
  logic signed [W_WIDTH-1:0]     w_data_i;
  logic                          data_valid_o;
  logic signed [OUT_WIDTH-1:0]   data_o;
  logic                          sop_o, eop_o, sof_o, eof_o, busy_o, ch_err_o;
  modport master (
    output data_valid_i, data_i, sop_i, eop_i, sof_i, eof_i, w_we_i, w_addr_i, w_data_i,
    input  data_valid_o, data_o, sop_o, eop_o, sof_o, eof_o, busy_o, ch_err_o
  );
  modport slave (
    input  data_valid_i, data_i, sop_i, eop_i, sof_i, eof_i, w_we_i, w_addr_i, w_data_i,
    output data_valid_o, data_o, sop_o, eop_o, sof_o, eof_o, busy_o, ch_err_o
  );
endinterface

// File: rtl/mac3x3_tree.sv
// mac3x3_tree: 9 signed products and a two-level adder tree with valid/tag sideband
module mac3x3_tree #(
  parameter int DATA_WIDTH = 8,
  parameter int W_WIDTH    = 8,
  parameter int TAG_W      = 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  valid,
  input  logic signed [DATA_WIDTH-1:0]          win [9],
  input  logic signed [W_WIDTH-1:0]             ker [9],
  input  logic [TAG_W-1:0]                      tag,
  output logic                                  sum_valid,
  output logic signed [DATA_WIDTH+W_WIDTH+3:0]  sum,
  output logic [TAG_W-1:0]                      sum_tag
);
  localparam int PW = DATA_WIDTH + W_WIDTH;
  logic signed [PW-1:0]   prod [9];
  logic signed [PW+1:0]   part [3];
  logic                   v1, v2;
  logic [TAG_W-1:0]       t1, t2;
  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      sum_valid <= 1'b0;
    end else begin
      v1 <= valid;
      v2 <= v1;
      sum_valid <= v2;
    end
  end
  always_ff @(posedge clk) begin
    t1 <= tag;
    t2 <= t1;
    sum_tag <= t2;
    for (int i = 0; i < 9; i++) prod[i] <= PW'(win[i]) * PW'(ker[i]);
    for (int r = 0; r < 3; r++) part[r] <= (PW+2)'(prod[3*r]) + (PW+2)'(prod[3*r+1]) + (PW+2)'(prod[3*r+2]);
    sum <= (PW+4)'(part[0]) + (PW+4)'(part[1]) + (PW+4)'(part[2]);
  end
endmodule

// File: rtl/conv3x3_mac.sv
// conv3x3_mac: channel-interleaved 3x3 convolution with bias, shift, ReLU and saturation
module conv3x3_mac import conv_pkg::*; #(
  parameter int DATA_WIDTH  = 8,
  parameter int W_WIDTH     = 8,
  parameter int MATRIX_SIZE = 3,
  parameter int CHANNEL_NUM = 3,
  parameter int OUT_WIDTH   = 8,
  parameter int SHIFT       = 7,
  parameter int RELU        = 1
) (
  input logic   clk,
  input logic   reset,
  conv_if.slave bus
);
  localparam int SW    = DATA_WIDTH + W_WIDTH + 4;
  localparam int ACC_W = acc_width(DATA_WIDTH, W_WIDTH, CHANNEL_NUM);
  localparam int CW    = CHANNEL_NUM > 1 ? $clog2(CHANNEL_NUM) : 1;
  localparam int NW    = CHANNEL_NUM * 9;
  localparam int AW    = $clog2(NW + 1);
  if (MATRIX_SIZE != 3) begin : g_size_chk
    $error("conv3x3_mac supports MATRIX_SIZE = 3 only");
  end
  logic signed [W_WIDTH-1:0]    w_mem [NW+1];
  logic [CW-1:0]                chan_cnt, ch;
  logic                         first_in, last_in, busy, ch_err;
  logic                         s0_valid;
  logic signed [DATA_WIDTH-1:0] s0_win [9];
  logic signed [W_WIDTH-1:0]    s0_ker [9];
  logic [5:0]                   s0_tag, t_tag;
  logic                         t_valid;
  logic signed [SW-1:0]         t_sum;
  logic signed [ACC_W-1:0]      acc;
  logic                         s4_last, s4_sop, s4_sof, s4_eop, s4_eof;
  logic signed [63:0]           res;
  // sop/sof resynchronise the channel counter to 0
  assign first_in = bus.sop_i | bus.sof_i;
  assign ch = first_in ? '0 : chan_cnt;
  assign last_in = ch == CW'(CHANNEL_NUM - 1);
  assign bus.busy_o = busy;
  assign bus.ch_err_o = ch_err;
  always_ff @(posedge clk) begin
    if (reset) begin
      chan_cnt <= '0;
      busy <= 1'b0;
      ch_err <= 1'b0;
      s0_valid <= 1'b0;
    end else begin
      s0_valid <= bus.data_valid_i;
      if (bus.data_valid_i) chan_cnt <= last_in ? '0 : ch + CW'(1);
      if (bus.data_valid_i && first_in && (chan_cnt != '0 || (bus.sof_i && busy))) ch_err <= 1'b1;
      if (bus.data_valid_i && bus.sof_i) busy <= 1'b1;
      else if (bus.eof_o) busy <= 1'b0;
    end
  end
  // weight/bias store survives reset and is frozen while a frame is in flight
  always_ff @(posedge clk) begin
    if (bus.w_we_i && !busy && bus.w_addr_i <= AW'(NW)) w_mem[bus.w_addr_i] <= bus.w_data_i;
  end
  always_ff @(posedge clk) begin
    s0_win <= bus.data_i;
    s0_tag <= {ch == '0, last_in, bus.sop_i, bus.sof_i, bus.eop_i, bus.eof_i};
    for (int k = 0; k < 9; k++) s0_ker[k] <= w_mem[AW'(int'(ch) * 9 + k)];
  end
  mac3x3_tree #(.DATA_WIDTH(DATA_WIDTH), .W_WIDTH(W_WIDTH), .TAG_W(6)) u_tree (
    .clk(clk), .reset(reset), .valid(s0_valid), .win(s0_win), .ker(s0_ker), .tag(s0_tag),
    .sum_valid(t_valid), .sum(t_sum), .sum_tag(t_tag)
  );
  always_ff @(posedge clk) begin
    if (reset) s4_last <= 1'b0;
    else s4_last <= t_valid & t_tag[4];
  end
  always_ff @(posedge clk) begin
    if (t_valid) begin
      acc <= t_tag[5] ? ACC_W'(t_sum) : acc + ACC_W'(t_sum);
      if (t_tag[5]) {s4_sop, s4_sof} <= t_tag[3:2];
      {s4_eop, s4_eof} <= t_tag[1:0];
    end
  end
  always_comb res = relu_sat((64'(acc) + 64'(w_mem[NW])) >>> SHIFT, OUT_WIDTH, RELU != 0);
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.data_valid_o <= 1'b0;
      bus.data_o <= '0;
      {bus.sop_o, bus.sof_o, bus.eop_o, bus.eof_o} <= '0;
    end else begin
      bus.data_valid_o <= s4_last;
      {bus.sop_o, bus.sof_o, bus.eop_o, bus.eof_o} <= {4{s4_last}} & {s4_sop, s4_sof, s4_eop, s4_eof};
      if (s4_last) bus.data_o <= res[OUT_WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_conv3x3_mac.sv
// tb_conv3x3_mac: scoreboard bench driving three differently configured MACs with one stream
module tb_conv3x3_mac;
  import conv_pkg::*;
  localparam int C = 3;
  localparam int NW = 27;
  localparam int SH [3] = '{0, 0, 7};
  localparam bit RL [3] = '{1'b1, 1'b0, 1'b0};
  typedef int win_t [9];
  typedef struct {int due; int d [3]; bit sop, sof, eop, eof;} exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_tests = 0;
  int n_fail = 0;
  int wm [NW+1];
  int m_ch = 0, m_acc = 0;
  bit m_sop, m_sof, m_err = 1'b0;
  exp_t q [$];
  exp_t mon_e;
  int last0 = 0;
  bit busy_chk = 1'b0;
  conv_if #(.DATA_WIDTH(8), .W_WIDTH(8), .CHANNEL_NUM(3), .OUT_WIDTH(8)) b0 ();
  conv_if #(.DATA_WIDTH(8), .W_WIDTH(8), .CHANNEL_NUM(3), .OUT_WIDTH(8)) b1 ();
  conv_if #(.DATA_WIDTH(8), .W_WIDTH(8), .CHANNEL_NUM(3), .OUT_WIDTH(8)) b2 ();
  assign {b1.data_valid_i, b1.sop_i, b1.eop_i, b1.sof_i, b1.eof_i, b1.w_we_i, b1.w_addr_i, b1.w_data_i} =
         {b0.data_valid_i, b0.sop_i, b0.eop_i, b0.sof_i, b0.eof_i, b0.w_we_i, b0.w_addr_i, b0.w_data_i};
  assign {b2.data_valid_i, b2.sop_i, b2.eop_i, b2.sof_i, b2.eof_i, b2.w_we_i, b2.w_addr_i, b2.w_data_i} =
         {b0.data_valid_i, b0.sop_i, b0.eop_i, b0.sof_i, b0.eof_i, b0.w_we_i, b0.w_addr_i, b0.w_data_i};
  assign b1.data_i = b0.data_i;
  assign b2.data_i = b0.data_i;
  conv3x3_mac #(.SHIFT(0), .RELU(1)) u_a (.clk(clk), .reset(reset), .bus(b0));
  conv3x3_mac #(.SHIFT(0), .RELU(0)) u_b (.clk(clk), .reset(reset), .bus(b1));
  conv3x3_mac #(.SHIFT(7), .RELU(0)) u_c (.clk(clk), .reset(reset), .bus(b2));

  function automatic void chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int ref_out(input int acc, input int sh, input bit relu);
    int r;
    r = (acc + wm[NW]) >>> sh;
    if (relu && r < 0) r = 0;
    return r > 127 ? 127 : r < -128 ? -128 : r;
  endfunction

  function automatic win_t fill(input int v);
    win_t w;
    foreach (w[k]) w[k] = v;
    return w;
  endfunction

  function automatic win_t rnd_win();
    win_t w;
    foreach (w[k]) w[k] = int'($urandom_range(0, 255)) - 128;
    return w;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      b0.data_valid_i = 1'b0;
      {b0.sop_i, b0.sof_i, b0.eop_i, b0.eof_i} = 4'($urandom);
      foreach (b0.data_i[k]) b0.data_i[k] = 8'($urandom);
      @(posedge clk);
      #1;
    end
    {b0.sop_i, b0.sof_i, b0.eop_i, b0.eof_i} = 4'b0;
  endtask

  task automatic beat(input win_t w, input bit sop, input bit sof, input bit eop, input bit eof);
    int dot = 0;
    exp_t e;
    b0.data_valid_i = 1'b1;
    {b0.sop_i, b0.sof_i, b0.eop_i, b0.eof_i} = {sop, sof, eop, eof};
    foreach (w[k]) b0.data_i[k] = 8'(w[k]);
    if ((sop || sof) && m_ch != 0) m_err = 1'b1;
    if (sop || sof) m_ch = 0;
    foreach (w[k]) dot += w[k] * wm[m_ch*9 + k];
    if (m_ch == 0) begin
      m_acc = dot;
      m_sop = sop;
      m_sof = sof;
    end else m_acc += dot;
    if (m_ch == C - 1) begin
      e.due = cyc + MAC_LATENCY;
      for (int g = 0; g < 3; g++) e.d[g] = ref_out(m_acc, SH[g], RL[g]);
      {e.sop, e.sof, e.eop, e.eof} = {m_sop, m_sof, eop, eof};
      q.push_back(e);
      m_ch = 0;
    end else m_ch++;
    @(posedge clk);
    #1;
    b0.data_valid_i = 1'b0;
    {b0.sop_i, b0.sof_i, b0.eop_i, b0.eof_i} = 4'b0;
    if (sof) chk("busy_set", int'(b0.busy_o), 1);
  endtask

  task automatic px(input win_t w0, input win_t w1, input win_t w2,
                    input bit sop, input bit sof, input bit eop, input bit eof, input int gap);
    beat(w0, sop, sof, 1'b0, 1'b0);
    idle($urandom_range(0, gap));
    beat(w1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle($urandom_range(0, gap));
    beat(w2, 1'b0, 1'b0, eop, eof);
  endtask

  task automatic wr(input int a, input int d, input bit accept);
    b0.w_we_i = 1'b1;
    b0.w_addr_i = 5'(a);
    b0.w_data_i = 8'(d);
    if (accept) wm[a] = d;
    @(posedge clk);
    #1;
    b0.w_we_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (b0.busy_o && n < 60) begin
      idle(1);
      n++;
    end
    chk("busy_timeout", int'(b0.busy_o), 0);
    idle(3);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (busy_chk) begin
        chk("busy_fall", int'(b0.busy_o), 0);
        busy_chk = 1'b0;
      end
      if (b0.data_valid_o) begin
        chk("out_expected", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          mon_e = q.pop_front();
          chk("latency", cyc, mon_e.due);
          chk("out_relu_sh0", int'(b0.data_o), mon_e.d[0]);
          chk("out_sh0", int'(b1.data_o), mon_e.d[1]);
          chk("out_sh7", int'(b2.data_o), mon_e.d[2]);
          chk("sop_o", int'(b0.sop_o), int'(mon_e.sop));
          chk("sof_o", int'(b0.sof_o), int'(mon_e.sof));
          chk("eop_o", int'(b0.eop_o), int'(mon_e.eop));
          chk("eof_o", int'(b0.eof_o), int'(mon_e.eof));
          busy_chk = mon_e.eof;
        end
        last0 = int'(b0.data_o);
      end else begin
        chk("data_hold", int'(b0.data_o), last0);
        chk("flags_idle", int'({b0.sop_o, b0.sof_o, b0.eop_o, b0.eof_o}), 0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    b0.data_valid_i = 1'b0;
    {b0.sop_i, b0.sof_i, b0.eop_i, b0.eof_i} = 4'b0;
    foreach (b0.data_i[k]) b0.data_i[k] = '0;
    b0.w_we_i = 1'b0;
    b0.w_addr_i = '0;
    b0.w_data_i = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_valid", int'(b0.data_valid_o), 0);
    chk("rst_data", int'(b2.data_o), 0);
    chk("rst_busy", int'(b0.busy_o), 0);
    chk("rst_err", int'(b0.ch_err_o), 0);
    for (int a = 0; a < NW; a++) wr(a, 1, 1'b1);
    wr(NW, 0, 1'b1);
    wr(28, 99, 1'b0);
    px(fill(1), fill(1), fill(1), 1'b1, 1'b1, 1'b1, 1'b1, 0);
    wait_idle();
    px(fill(-1), fill(-1), fill(-1), 1'b1, 1'b1, 1'b1, 1'b1, 0);
    wait_idle();
    for (int a = 0; a < NW; a++) wr(a, 127, 1'b1);
    px(fill(127), fill(127), fill(127), 1'b1, 1'b1, 1'b1, 1'b1, 2);
    wait_idle();
    px(fill(-128), fill(-128), fill(-128), 1'b1, 1'b1, 1'b1, 1'b1, 2);
    wait_idle();
    for (int a = 0; a < NW; a++) wr(a, (a % 9 == 0) ? 1 : 0, 1'b1);
    wr(NW, 64, 1'b1);
    begin
      win_t w0, w1;
      w0 = fill(0);
      w0[0] = 64;
      px(w0, fill(0), fill(0), 1'b1, 1'b1, 1'b1, 1'b1, 0);
      wait_idle();
      wr(NW, 0, 1'b1);
      w0[0] = -100;
      w1 = fill(0);
      w1[0] = -100;
      px(w0, w1, fill(0), 1'b1, 1'b1, 1'b1, 1'b1, 3);
      wait_idle();
    end
    for (int a = 0; a <= NW; a++) wr(a, int'($urandom_range(0, 255)) - 128, 1'b1);
    for (int f = 0; f < 2; f++) begin
      for (int l = 0; l < 2; l++)
        for (int p = 0; p < 3; p++) begin
          px(rnd_win(), rnd_win(), rnd_win(), p == 0, l == 0 && p == 0, p == 2, l == 1 && p == 2, 5);
          idle($urandom_range(0, 5));
        end
      wait_idle();
    end
    chk("ch_err_clean", int'(b0.ch_err_o), int'(m_err));
    beat(rnd_win(), 1'b1, 1'b1, 1'b0, 1'b0);
    beat(rnd_win(), 1'b0, 1'b0, 1'b0, 1'b0);
    beat(rnd_win(), 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ch_err_set", int'(b0.ch_err_o), int'(m_err));
    wr(0, wm[0] == 127 ? 126 : wm[0] + 1, 1'b0);
    beat(rnd_win(), 1'b0, 1'b0, 1'b0, 1'b0);
    beat(rnd_win(), 1'b0, 1'b0, 1'b1, 1'b0);
    px(fill(50), fill(-30), fill(20), 1'b1, 1'b0, 1'b1, 1'b1, 4);
    wait_idle();
    px(fill(50), fill(-30), fill(20), 1'b1, 1'b1, 1'b1, 1'b1, 1);
    wait_idle();
    chk("ch_err_sticky", int'(b0.ch_err_o), int'(m_err));
    idle(10);
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
